// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_pipe
// Description : Writeback / retirement stage. Accepts one instruction at a
//               time, resolves branch and jump targets, aligns and extends load
//               data, and drives the register-file write port, the redirect
//               port and the retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    // Upstream handshake
    input  logic              in_valid,
    output logic              in_ready,

    // Instruction payload
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [5:0]        b_ins,
    input  logic [3:0]        flags,
    input  logic [1:0]        j_ins,
    input  logic [1:0]        u_ins,
    input  logic              ren,
    input  logic [1:0]        ld_size,
    input  logic              ld_unsigned,
    input  logic [4:0]        rd,
    input  logic              rd_wen,

    // Load data return
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,

    // Register-file write port
    output logic              wb_wen,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,

    // Control-flow redirect
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              misalign,

    // Retirement counter
    output logic [CNT_W-1:0]  retired
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT_MEM = 1'b1;

    // Field positions inside the packed one-hot control vectors
    localparam int B_BEQ  = 5;
    localparam int B_BNE  = 4;
    localparam int B_BGE  = 3;
    localparam int B_BLT  = 2;
    localparam int B_BGEU = 1;
    localparam int B_BLTU = 0;
    localparam int F_ZF   = 3;
    localparam int F_CF   = 2;
    localparam int F_OF   = 1;
    localparam int F_SF   = 0;
    localparam int J_JAL  = 1;
    localparam int J_JALR = 0;
    localparam int U_LUI  = 1;
    localparam int U_AUIPC = 0;

    logic [0:0]        state_q, state_d;
    logic              accept;
    logic              retire_now;

    // Instruction captured at acceptance (used while a load waits for data)
    logic [XLEN-1:0]   pc_q, imm_q, alu_q;
    logic [5:0]        b_ins_q;
    logic [3:0]        flags_q;
    logic [1:0]        j_ins_q, u_ins_q;
    logic              ren_q;
    logic [1:0]        ld_size_q;
    logic              ld_unsigned_q;
    logic [4:0]        rd_q;
    logic              rd_wen_q;

    // Instruction being retired this cycle: live inputs in IDLE, captured copy
    // in WAIT_MEM
    logic [XLEN-1:0]   sel_pc, sel_imm, sel_alu;
    logic [5:0]        sel_b;
    logic [3:0]        sel_f;
    logic [1:0]        sel_j, sel_u;
    logic              sel_ren;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [4:0]        sel_rd;
    logic              sel_rd_wen;

    // Control-flow and datapath results
    logic              lt_signed;
    logic              taken;
    logic              ctrl_xfer;
    logic [XLEN-1:0]   pc_plus_imm;
    logic [XLEN-1:0]   pc_plus_4;
    logic [XLEN-1:0]   target;
    logic              target_misaligned;
    logic [XLEN-1:0]   result;

    // Load alignment
    logic [1:0]        eff_size;
    logic [2:0]        lane_off;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   size_mask;
    logic              sign_bit;
    logic [XLEN-1:0]   load_data;

    // Registered outputs and their next values
    logic              wb_wen_q, wb_wen_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load parks in WAIT_MEM until the first data beat arrives
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && ren) begin
                    state_d = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the stage only takes new work while idle
    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    assign accept = in_valid & in_ready;

    // Non-loads retire in the cycle they are accepted; loads on their data beat.
    // mem_rvalid seen while IDLE never reaches this term.
    assign retire_now = (accept & ~ren) |
                        ((state_q == S_WAIT_MEM) & mem_rvalid);

    // ------------------------------------------------------------------------
    // Instruction capture
    // ------------------------------------------------------------------------

    // Hold the accepted instruction so a pending load still knows its fields
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            imm_q         <= '0;
            alu_q         <= '0;
            b_ins_q       <= '0;
            flags_q       <= '0;
            j_ins_q       <= '0;
            u_ins_q       <= '0;
            ren_q         <= 1'b0;
            ld_size_q     <= '0;
            ld_unsigned_q <= 1'b0;
            rd_q          <= '0;
            rd_wen_q      <= 1'b0;
        end else if (accept) begin
            pc_q          <= pc;
            imm_q         <= imm;
            alu_q         <= alu_result;
            b_ins_q       <= b_ins;
            flags_q       <= flags;
            j_ins_q       <= j_ins;
            u_ins_q       <= u_ins;
            ren_q         <= ren;
            ld_size_q     <= ld_size;
            ld_unsigned_q <= ld_unsigned;
            rd_q          <= rd;
            rd_wen_q      <= rd_wen;
        end
    end

    // Pick the instruction that retires this cycle
    always_comb begin
        if (state_q == S_IDLE) begin
            sel_pc     = pc;
            sel_imm    = imm;
            sel_alu    = alu_result;
            sel_b      = b_ins;
            sel_f      = flags;
            sel_j      = j_ins;
            sel_u      = u_ins;
            sel_ren    = ren;
            sel_size   = ld_size;
            sel_uns    = ld_unsigned;
            sel_rd     = rd;
            sel_rd_wen = rd_wen;
        end else begin
            sel_pc     = pc_q;
            sel_imm    = imm_q;
            sel_alu    = alu_q;
            sel_b      = b_ins_q;
            sel_f      = flags_q;
            sel_j      = j_ins_q;
            sel_u      = u_ins_q;
            sel_ren    = ren_q;
            sel_size   = ld_size_q;
            sel_uns    = ld_unsigned_q;
            sel_rd     = rd_q;
            sel_rd_wen = rd_wen_q;
        end
    end

    // ------------------------------------------------------------------------
    // Branch / jump resolution
    // ------------------------------------------------------------------------

    // Taken decision from the a-b flags, and the target address
    always_comb begin
        lt_signed   = sel_f[F_SF] ^ sel_f[F_OF];
        taken       = sel_j[J_JAL]
                    | (sel_b[B_BEQ]  &  sel_f[F_ZF])
                    | (sel_b[B_BNE]  & ~sel_f[F_ZF])
                    | (sel_b[B_BLT]  &  lt_signed)
                    | (sel_b[B_BGE]  & ~lt_signed)
                    | (sel_b[B_BLTU] &  sel_f[F_CF])
                    | (sel_b[B_BGEU] & ~sel_f[F_CF]);
        ctrl_xfer   = taken | sel_j[J_JALR];
        pc_plus_imm = sel_pc + sel_imm;
        pc_plus_4   = sel_pc + XLEN'(4);
        if (sel_j[J_JALR]) begin
            target = {sel_alu[XLEN-1:1], 1'b0};
        end else begin
            target = pc_plus_imm;
        end
        target_misaligned = ctrl_xfer & (target[1:0] != 2'b00);
    end

    // ------------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------------

    // Shift the addressed lane down to bit 0, then mask and extend it
    always_comb begin
        eff_size = sel_size;
        if ((XLEN == 32) && (sel_size == 2'b11)) begin
            eff_size = 2'b10;
        end

        case (eff_size)
            2'b00:   lane_off = sel_alu[2:0];
            2'b01:   lane_off = {sel_alu[2:1], 1'b0};
            2'b10:   lane_off = {sel_alu[2], 2'b00};
            default: lane_off = 3'b000;
        endcase
        // A 32-bit word has only four byte lanes
        if (XLEN == 32) begin
            lane_off[2] = 1'b0;
        end

        shifted = mem_rdata >> {lane_off, 3'b000};

        case (eff_size)
            2'b00: begin
                size_mask = XLEN'(8'hFF);
                sign_bit  = shifted[7];
            end
            2'b01: begin
                size_mask = XLEN'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            2'b10: begin
                size_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                size_mask = '1;
                sign_bit  = shifted[XLEN-1];
            end
        endcase

        load_data = (shifted & size_mask) |
                    ((sign_bit & ~sel_uns) ? ~size_mask : '0);
    end

    // Writeback value, highest priority first
    always_comb begin
        if (sel_u[U_LUI]) begin
            result = sel_imm;
        end else if (sel_u[U_AUIPC]) begin
            result = pc_plus_imm;
        end else if (sel_j[J_JAL] || sel_j[J_JALR]) begin
            result = pc_plus_4;
        end else if (sel_ren) begin
            result = load_data;
        end else begin
            result = sel_alu;
        end
    end

    // ------------------------------------------------------------------------
    // Retirement outputs
    // ------------------------------------------------------------------------

    // Next output values: pulses clear when nothing retires, payloads hold
    always_comb begin
        wb_wen_d         = 1'b0;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        misalign_d       = 1'b0;
        retired_d        = retired_q;
        if (retire_now) begin
            wb_wen_d         = sel_rd_wen & (sel_rd != 5'd0) & ~target_misaligned;
            wb_rd_d          = sel_rd;
            wb_data_d        = result;
            redirect_valid_d = ctrl_xfer & ~target_misaligned;
            redirect_pc_d    = target;
            misalign_d       = target_misaligned;
            retired_d        = retired_q + CNT_W'(1);
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wen_q         <= 1'b0;
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misalign_q       <= 1'b0;
            retired_q        <= '0;
        end else begin
            wb_wen_q         <= wb_wen_d;
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_q       <= misalign_d;
            retired_q        <= retired_d;
        end
    end

    assign wb_wen         = wb_wen_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign misalign       = misalign_q;
    assign retired        = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_pipe
// Description : Self-checking bench for wb_stage_pipe. Drives an XLEN=32 /
//               CNT_W=4 instance and an XLEN=64 / CNT_W=32 instance from the
//               same stimulus and compares both against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus (the 32-bit instance sees the low halves)
    logic        rst, in_valid, ren, ld_unsigned, rd_wen, mem_rvalid;
    logic [63:0] pc, imm, alu, mem_rdata;
    logic [5:0]  b_ins;
    logic [3:0]  flags;
    logic [1:0]  j_ins, u_ins, ld_size;
    logic [4:0]  rd;

    // XLEN=32 instance outputs
    logic        a_in_ready, a_wb_wen, a_rv, a_mis;
    logic [4:0]  a_wb_rd;
    logic [31:0] a_wb_data, a_rpc;
    logic [3:0]  a_retired;

    // XLEN=64 instance outputs
    logic        b_in_ready, b_wb_wen, b_rv, b_mis;
    logic [4:0]  b_wb_rd;
    logic [63:0] b_wb_data, b_rpc;
    logic [31:0] b_retired;

    wb_stage_pipe #(.XLEN(32), .CNT_W(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .pc(pc[31:0]), .imm(imm[31:0]), .alu_result(alu[31:0]),
        .b_ins(b_ins), .flags(flags), .j_ins(j_ins), .u_ins(u_ins),
        .ren(ren), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .rd(rd), .rd_wen(rd_wen), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
        .wb_wen(a_wb_wen), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
        .redirect_valid(a_rv), .redirect_pc(a_rpc), .misalign(a_mis), .retired(a_retired)
    );

    wb_stage_pipe #(.XLEN(64), .CNT_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .pc(pc), .imm(imm), .alu_result(alu),
        .b_ins(b_ins), .flags(flags), .j_ins(j_ins), .u_ins(u_ins),
        .ren(ren), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .rd(rd), .rd_wen(rd_wen), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_wen(b_wb_wen), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
        .redirect_valid(b_rv), .redirect_pc(b_rpc), .misalign(b_mis), .retired(b_retired)
    );

    typedef struct {
        logic [63:0] pc, imm, alu;
        logic [5:0]  b;
        logic [3:0]  f;
        logic [1:0]  j, u;
        logic        ren;
        logic [1:0]  sz;
        logic        uns;
        logic [4:0]  rd;
        logic        rdw;
    } instr_t;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        rv;
        logic [63:0] rpc;
        logic        mis;
    } res_t;

    typedef struct {
        instr_t      ins;
        logic        ewen;
        logic [31:0] edata;
        logic        erv;
        logic [31:0] erpc;
        logic        emis;
    } tv_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index 0 = XLEN 32, index 1 = XLEN 64
    bit          m_wait;
    instr_t      m_pend;
    res_t        m_out[2];
    bit          m_rpc_known[2];
    logic [63:0] m_ret[2];
    logic [63:0] m_cnt_mask[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Retirement result computed straight from the architectural rules
    function automatic res_t model_retire(input int xlen, input instr_t v, input logic [63:0] rdata_in);
        res_t         r;
        logic [63:0]  m, pcv, immv, aluv, sum, tgt, rdata, ld;
        logic [127:0] val, lm;
        bit           taken, jalr, lt, ctrl, mis;
        int           nb, wb, start;
        m     = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        pcv   = v.pc & m;
        immv  = v.imm & m;
        aluv  = v.alu & m;
        rdata = rdata_in & m;
        sum   = (pcv + immv) & m;
        jalr  = v.j[0];
        lt    = v.f[0] ^ v.f[1];
        taken = v.j[1] | (v.b[5] & v.f[3]) | (v.b[4] & ~v.f[3]) | (v.b[2] & lt) |
                (v.b[3] & ~lt) | (v.b[0] & v.f[2]) | (v.b[1] & ~v.f[2]);
        tgt   = jalr ? (aluv & ~64'd1) : sum;
        ctrl  = taken | jalr;
        mis   = ctrl && ((tgt % 4) != 0);
        // Load: naturally aligned lane of nb bytes inside the memory word
        nb = 1 << v.sz;
        if (xlen == 32 && nb == 8) nb = 4;
        wb    = xlen / 8;
        start = (int'(aluv % 64'(wb)) / nb) * nb;
        val   = {64'd0, rdata} >> (8 * start);
        lm    = (128'd1 << (8 * nb)) - 128'd1;
        val   = val & lm;
        if (!v.uns && val[8*nb-1]) val = val | ~lm;
        ld    = val[63:0] & m;
        if (v.u[1])                r.data = immv;
        else if (v.u[0])           r.data = sum;
        else if (v.j[1] || v.j[0]) r.data = (pcv + 64'd4) & m;
        else if (v.ren)            r.data = ld;
        else                       r.data = aluv;
        r.rd  = v.rd;
        r.rv  = ctrl && !mis;
        r.rpc = tgt;
        r.mis = mis;
        r.wen = v.rdw && (v.rd != 5'd0) && !mis;
        return r;
    endfunction

    function automatic instr_t cur_instr();
        instr_t v;
        v.pc = pc; v.imm = imm; v.alu = alu; v.b = b_ins; v.f = flags;
        v.j = j_ins; v.u = u_ins; v.ren = ren; v.sz = ld_size; v.uns = ld_unsigned;
        v.rd = rd; v.rdw = rd_wen;
        return v;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        instr_t v, r;
        bit     do_ret;
        logic [63:0] rdat;
        res_t   x;
        v = cur_instr();
        do_ret = 1'b0;
        rdat = '0;
        r = v;
        if (rst) begin
            m_wait = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_out[i] = '{1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0};
                m_rpc_known[i] = 1'b1;
                m_ret[i] = '0;
            end
            return;
        end
        if (!m_wait) begin
            if (in_valid) begin
                if (v.ren) begin
                    m_pend = v;
                    m_wait = 1'b1;
                end else begin
                    do_ret = 1'b1;
                end
            end
        end else if (mem_rvalid) begin
            do_ret = 1'b1;
            r = m_pend;
            rdat = mem_rdata;
            m_wait = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (do_ret) begin
                x = model_retire(i == 0 ? 32 : 64, r, rdat);
                m_out[i].wen  = x.wen;
                m_out[i].rd   = x.rd;
                m_out[i].data = x.data;
                m_out[i].rv   = x.rv;
                m_out[i].mis  = x.mis;
                if (x.rv) begin
                    m_out[i].rpc   = x.rpc;
                    m_rpc_known[i] = 1'b1;
                end else begin
                    m_rpc_known[i] = 1'b0;
                end
                m_ret[i] = (m_ret[i] + 64'd1) & m_cnt_mask[i];
            end else begin
                m_out[i].wen = 1'b0;
                m_out[i].rv  = 1'b0;
                m_out[i].mis = 1'b0;
            end
        end
    endtask

    task automatic check_duts();
        chk("d32.in_ready", 64'(a_in_ready), 64'(!m_wait));
        chk("d32.wb_wen",   64'(a_wb_wen),   64'(m_out[0].wen));
        chk("d32.wb_rd",    64'(a_wb_rd),    64'(m_out[0].rd));
        chk("d32.wb_data",  64'(a_wb_data),  m_out[0].data);
        chk("d32.redirect_valid", 64'(a_rv), 64'(m_out[0].rv));
        if (m_rpc_known[0]) chk("d32.redirect_pc", 64'(a_rpc), m_out[0].rpc);
        chk("d32.misalign", 64'(a_mis),      64'(m_out[0].mis));
        chk("d32.retired",  64'(a_retired),  m_ret[0]);
        chk("d64.in_ready", 64'(b_in_ready), 64'(!m_wait));
        chk("d64.wb_wen",   64'(b_wb_wen),   64'(m_out[1].wen));
        chk("d64.wb_rd",    64'(b_wb_rd),    64'(m_out[1].rd));
        chk("d64.wb_data",  b_wb_data,       m_out[1].data);
        chk("d64.redirect_valid", 64'(b_rv), 64'(m_out[1].rv));
        if (m_rpc_known[1]) chk("d64.redirect_pc", b_rpc, m_out[1].rpc);
        chk("d64.misalign", 64'(b_mis),      64'(m_out[1].mis));
        chk("d64.retired",  64'(b_retired),  m_ret[1]);
    endtask

    // One clock: model sees the inputs, DUTs sample them, outputs checked after
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_duts();
    endtask

    task automatic set_idle();
        rst = 1'b0; in_valid = 1'b0; ren = 1'b0; ld_unsigned = 1'b0; rd_wen = 1'b0;
        mem_rvalid = 1'b0; pc = '0; imm = '0; alu = '0; mem_rdata = '0;
        b_ins = '0; flags = '0; j_ins = '0; u_ins = '0; ld_size = '0; rd = '0;
    endtask

    task automatic drive(input instr_t v);
        pc = v.pc; imm = v.imm; alu = v.alu; b_ins = v.b; flags = v.f;
        j_ins = v.j; u_ins = v.u; ren = v.ren; ld_size = v.sz; ld_unsigned = v.uns;
        rd = v.rd; rd_wen = v.rdw;
    endtask

    function automatic instr_t mkins(input logic [63:0] p, input logic [63:0] i, input logic [63:0] a,
                                     input logic [5:0] b, input logic [3:0] f, input logic [1:0] j,
                                     input logic [1:0] u, input logic [4:0] d, input logic w);
        instr_t v;
        v.pc = p; v.imm = i; v.alu = a; v.b = b; v.f = f; v.j = j; v.u = u;
        v.ren = 1'b0; v.sz = 2'b00; v.uns = 1'b0; v.rd = d; v.rdw = w;
        return v;
    endfunction

    function automatic instr_t mkload(input logic [63:0] a, input logic [1:0] sz,
                                      input logic uns, input logic [4:0] d);
        instr_t v;
        v = mkins(64'h0, 64'h0, a, 6'b0, 4'b0, 2'b0, 2'b0, d, 1'b1);
        v.ren = 1'b1; v.sz = sz; v.uns = uns;
        return v;
    endfunction

    function automatic instr_t rand_instr();
        instr_t v;
        int k;
        v.pc  = {$urandom, $urandom};
        v.imm = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
        v.alu = {$urandom, $urandom};
        v.b   = ($urandom_range(0, 7) < 5) ? 6'(1 << $urandom_range(0, 5)) : 6'b0;
        v.f   = 4'($urandom);
        k     = $urandom_range(0, 9);
        v.j   = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00;
        k     = $urandom_range(0, 9);
        v.u   = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00;
        v.ren = ($urandom_range(0, 3) == 0);
        v.sz  = 2'($urandom);
        v.uns = 1'($urandom);
        v.rd  = 5'($urandom);
        v.rdw = 1'($urandom);
        return v;
    endfunction

    tv_t tbl[13];

    initial begin
        int zeros;
        m_cnt_mask[0] = 64'hF;
        m_cnt_mask[1] = 64'hFFFF_FFFF;
        m_wait = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_out[i] = '{1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0};
            m_rpc_known[i] = 1'b1;
            m_ret[i] = '0;
        end

        //            pc        imm                    alu        b_ins      flags    j      u      rd  rdw   wen  data          rv   rpc         mis
        tbl[0]  = '{mkins(64'h100,  64'h20,  64'h55,   6'b100000, 4'b1000, 2'b00, 2'b00, 5'd0,  1'b0), 1'b0, 32'h55,       1'b1, 32'h120,  1'b0};
        tbl[1]  = '{mkins(64'h40,   64'h0,   64'h2003, 6'b000000, 4'b0000, 2'b01, 2'b00, 5'd1,  1'b1), 1'b0, 32'h44,       1'b0, 32'h0,    1'b1};
        tbl[2]  = '{mkins(64'h0,    64'h12345000, 64'h0, 6'b0,    4'b0000, 2'b00, 2'b10, 5'd0,  1'b1), 1'b0, 32'h12345000, 1'b0, 32'h0,    1'b0};
        tbl[3]  = '{mkins(64'h0,    64'h12345000, 64'h0, 6'b0,    4'b0000, 2'b00, 2'b10, 5'd5,  1'b1), 1'b1, 32'h12345000, 1'b0, 32'h0,    1'b0};
        tbl[4]  = '{mkins(64'h200,  64'h40,  64'h7,    6'b010000, 4'b1000, 2'b00, 2'b00, 5'd3,  1'b1), 1'b1, 32'h7,        1'b0, 32'h0,    1'b0};
        tbl[5]  = '{mkins(64'h300,  64'hFFFF_FFFF_FFFF_FFF8, 64'h9, 6'b000100, 4'b0001, 2'b00, 2'b00, 5'd4, 1'b1), 1'b1, 32'h9, 1'b1, 32'h2F8, 1'b0};
        tbl[6]  = '{mkins(64'h1000, 64'h5000, 64'h0,   6'b000000, 4'b0000, 2'b00, 2'b01, 5'd7,  1'b1), 1'b1, 32'h6000,     1'b0, 32'h0,    1'b0};
        tbl[7]  = '{mkins(64'h80,   64'h102, 64'h0,    6'b000000, 4'b0000, 2'b10, 2'b00, 5'd1,  1'b1), 1'b0, 32'h84,       1'b0, 32'h0,    1'b1};
        tbl[8]  = '{mkins(64'h80,   64'h100, 64'h0,    6'b000000, 4'b0000, 2'b10, 2'b00, 5'd1,  1'b1), 1'b1, 32'h84,       1'b1, 32'h180,  1'b0};
        tbl[9]  = '{mkins(64'h10,   64'h10,  64'h0,    6'b000001, 4'b0100, 2'b00, 2'b00, 5'd0,  1'b0), 1'b0, 32'h0,        1'b1, 32'h20,   1'b0};
        tbl[10] = '{mkins(64'h10,   64'h10,  64'h3C,   6'b000010, 4'b0100, 2'b00, 2'b00, 5'd6,  1'b1), 1'b1, 32'h3C,       1'b0, 32'h0,    1'b0};
        tbl[11] = '{mkins(64'h400,  64'h10,  64'h1,    6'b001000, 4'b0011, 2'b00, 2'b00, 5'd0,  1'b1), 1'b0, 32'h1,        1'b1, 32'h410,  1'b0};
        tbl[12] = '{mkins(64'h50,   64'h0,   64'h3001, 6'b000000, 4'b0000, 2'b01, 2'b00, 5'd31, 1'b1), 1'b1, 32'h54,       1'b1, 32'h3000, 1'b0};

        // Reset
        set_idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset.wb_wen",  64'(a_wb_wen), 64'd0);
        chk("reset.wb_data", 64'(a_wb_data), 64'd0);
        chk("reset.retired", 64'(a_retired), 64'd0);
        chk("reset.in_ready", 64'(a_in_ready), 64'd1);

        // Single-cycle instructions from the table
        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].ins);
            in_valid = 1'b1;
            cycle();
            chk($sformatf("tbl%0d.wb_wen", k),   64'(a_wb_wen),  64'(tbl[k].ewen));
            chk($sformatf("tbl%0d.wb_data", k),  64'(a_wb_data), 64'(tbl[k].edata));
            chk($sformatf("tbl%0d.redirect_valid", k), 64'(a_rv), 64'(tbl[k].erv));
            if (tbl[k].erv) chk($sformatf("tbl%0d.redirect_pc", k), 64'(a_rpc), 64'(tbl[k].erpc));
            chk($sformatf("tbl%0d.misalign", k), 64'(a_mis),     64'(tbl[k].emis));
        end
        set_idle();
        cycle();

        // lb / lbu with data three cycles after acceptance; a stray rvalid in the
        // acceptance cycle and a competing in_valid while waiting are ignored
        for (int u = 0; u < 2; u++) begin
            set_idle();
            drive(mkload(64'h1003, 2'b00, 1'(u), 5'd2));
            in_valid = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata = 64'h0000_0000_1111_1111;
            cycle();
            zeros = (a_in_ready == 1'b0) ? 1 : 0;
            drive(mkins(64'h0, 64'h0, 64'hDEAD, 6'b0, 4'b0, 2'b0, 2'b0, 5'd9, 1'b1));
            mem_rvalid = 1'b0;
            for (int w = 0; w < 2; w++) begin
                cycle();
                if (a_in_ready == 1'b0) zeros++;
            end
            in_valid = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = 64'h0000_0000_80FF_FFFF;
            cycle();
            chk("load.busy_cycles", 64'(zeros), 64'd3);
            chk("load.wb_wen", 64'(a_wb_wen), 64'd1);
            chk("load.d32.wb_data", 64'(a_wb_data), (u == 0) ? 64'hFFFF_FF80 : 64'h80);
            chk("load.d64.wb_data", b_wb_data, (u == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
            set_idle();
            cycle();
        end

        // Reset while a load waits, with data arriving in the same cycle
        drive(mkload(64'h1000, 2'b10, 1'b0, 5'd4));
        in_valid = 1'b1;
        cycle();
        set_idle();
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 64'h1234_5678_9ABC_DEF0;
        cycle();
        set_idle();
        chk("rstwait.wb_wen", 64'(a_wb_wen), 64'd0);
        chk("rstwait.retired", 64'(a_retired), 64'd0);
        chk("rstwait.in_ready", 64'(a_in_ready), 64'd1);
        cycle();
        chk("rstwait.no_late_retire", 64'(a_retired), 64'd0);

        // 17 back-to-back ALU ops: the 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            drive(mkins(64'(i * 4), 64'h0, 64'(i + 100), 6'b0, 4'b0, 2'b0, 2'b0, 5'(i), 1'b1));
            in_valid = 1'b1;
            cycle();
        end
        chk("wrap.d32.retired", 64'(a_retired), 64'd1);
        chk("wrap.d64.retired", 64'(b_retired), 64'd17);
        set_idle();

        // Signed dword load: unchanged at XLEN 64, treated as a word at XLEN 32
        drive(mkload(64'h2000, 2'b11, 1'b0, 5'd3));
        in_valid = 1'b1;
        cycle();
        set_idle();
        mem_rvalid = 1'b1;
        mem_rdata = 64'h8123_4567_89AB_CDEF;
        cycle();
        chk("dword.d64.wb_data", b_wb_data, 64'h8123_4567_89AB_CDEF);
        chk("dword.d32.wb_data", 64'(a_wb_data), 64'h89AB_CDEF);
        set_idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive(rand_instr());
            in_valid   = ($urandom_range(0, 9) < 7);
            mem_rvalid = ($urandom_range(0, 9) < 4);
            mem_rdata  = {$urandom, $urandom};
            rst        = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
